// File: rtl/ram_sp_resp_if.sv
// ram_sp_resp_if: request/response bundle between the RAM controller and the
// single-port RAM responder.
//
// Handshake semantics: there is no ready/backpressure. rd_en and wr_en are
// request strobes that the responder samples on every rising sys_clk edge.
// The responder answers a read with rd_valid, a one-cycle strobe in the cycle
// after the request, with rd_data held stable until the next read response.
// req_drop, addr_err and par_err are single-cycle status pulses. par_err is
// aligned with rd_valid. wr_cnt is a level that changes only on accepted
// writes.
//
// Signals:
//   rd_en, wr_en, addr, wr_data, err_inj   controller -> responder
//   rd_data, rd_valid, init_busy,
//   req_drop, addr_err, par_err, wr_cnt    responder -> controller
//   state_dbg                              responder FSM state, 0=INIT 1=IDLE
interface ram_sp_resp_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              err_inj;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;
    logic              req_drop;
    logic              addr_err;
    logic              par_err;
    logic [CNT_W-1:0]  wr_cnt;
    logic              state_dbg;

    modport master (
        output rd_en, wr_en, addr, wr_data, err_inj,
        input  rd_data, rd_valid, init_busy, req_drop, addr_err, par_err,
               wr_cnt, state_dbg
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data, err_inj,
        output rd_data, rd_valid, init_busy, req_drop, addr_err, par_err,
               wr_cnt, state_dbg
    );
endinterface

// File: rtl/ram_sp_resp.sv
// ram_sp_resp: single-port synchronous RAM responder.
//
// After every reset the array is cleared by an init sweep that writes
// INIT_VAL to one word per cycle (DEPTH cycles). Requests arriving during
// the sweep are dropped and flagged with req_drop. Once idle, a read returns
// data one cycle later with a rd_valid strobe, and a write stores the data
// and bumps a saturating write counter. A simultaneous read and write are
// both performed; the read sees the pre-write content. Addresses at or
// above DEPTH are flagged with addr_err. An out-of-range write is discarded,
// and an out-of-range read returns zero.
//
// Optional feature (macro PARITY_RAM_EN): each word carries an even-parity
// bit. A write with err_inj=1 stores inverted parity, and a read whose
// stored parity does not match pulses par_err alongside rd_valid. Without
// the macro, err_inj is ignored and par_err is constant 0.
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        ram_sp_resp_if.slave (request inputs, registered outputs)
module ram_sp_resp #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    ram_sp_resp_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef PARITY_RAM_EN
    localparam int MEM_W = DATA_W + 1;
    localparam logic [MEM_W-1:0] INIT_WORD = {^INIT_VAL, INIT_VAL};
`else
    localparam int MEM_W = DATA_W;
    localparam logic [MEM_W-1:0] INIT_WORD = INIT_VAL;
`endif

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]  init_ptr;

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              req_drop_q;
    logic              addr_err_q;
    logic              par_err_q;
    logic [CNT_W-1:0]  wr_cnt_q;

    // Per-cycle decode of the current request.
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              par_bad;

    // FSM/control outputs from the combinational process.
    logic              init_we;
    logic              rd_take;
    logic              acc_rd;
    logic              acc_wr;
    logic              drop_d;
    logic              aerr_d;

    // One extra bit so DEPTH == 2**ADDR_W compares correctly.
    assign in_range = ({1'b0, bus.addr} < AW1'(DEPTH));
    assign idx      = bus.addr[IDX_W-1:0];
    assign rd_word  = mem[idx];

`ifdef PARITY_RAM_EN
    assign wr_word = {(^bus.wr_data) ^ bus.err_inj, bus.wr_data};
    assign par_bad = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
    logic unused_err_inj;
    assign unused_err_inj = bus.err_inj;
    assign wr_word = bus.wr_data;
    assign par_bad = 1'b0;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d = state_q;
        init_we = 1'b0;
        rd_take = 1'b0;
        acc_rd  = 1'b0;
        acc_wr  = 1'b0;
        drop_d  = 1'b0;
        aerr_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                drop_d  = bus.rd_en | bus.wr_en;
                // The last word is written on the same edge that leaves INIT.
                if (init_ptr == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rd_take = bus.rd_en;
                acc_rd  = bus.rd_en & in_range;
                acc_wr  = bus.wr_en & in_range;
                aerr_d  = (bus.rd_en | bus.wr_en) & ~in_range;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control registers and outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_INIT;
            init_ptr   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            req_drop_q <= 1'b0;
            addr_err_q <= 1'b0;
            par_err_q  <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (init_we) begin
                init_ptr <= (init_ptr == LAST_IDX) ? '0 : init_ptr + 1'b1;
            end
            rd_valid_q <= rd_take;
            // Out-of-range reads still answer, with zero data.
            if (rd_take) begin
                rd_data_q <= acc_rd ? rd_word[DATA_W-1:0] : '0;
            end
            req_drop_q <= drop_d;
            addr_err_q <= aerr_d;
            par_err_q  <= acc_rd & par_bad;
            if (acc_wr && (wr_cnt_q != {CNT_W{1'b1}})) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    // Storage is not reset; the sweep clears it. While reset is held the
    // FSM sits in INIT and harmlessly rewrites word 0 with INIT_WORD.
    // Read-first behaviour falls out of the non-blocking write here versus
    // the read sampled in the control block on the same edge.
    always_ff @(posedge sys_clk) begin
        if (init_we) begin
            mem[init_ptr] <= INIT_WORD;
        end else if (acc_wr) begin
            mem[idx] <= wr_word;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = (state_q == ST_INIT);
    assign bus.req_drop  = req_drop_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.par_err   = par_err_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ram_sp_resp.sv
// tb_ram_sp_resp: two responders share one stimulus stream. Instance 0 uses
// the default sizing (DEPTH 256, 16-bit counter). Instance 1 uses DEPTH 200
// and a 4-bit counter, so out-of-range addresses and counter saturation
// occur. A reference model updates at each rising edge and pushes the
// expected read responses into per-instance queues. A monitor on the falling
// edge compares every output against the model.
module tb_ram_sp_resp;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

`ifdef PARITY_RAM_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic              rd_en   = 1'b0;
    logic              wr_en   = 1'b0;
    logic              err_inj = 1'b0;
    logic [ADDR_W-1:0] addr    = '0;
    logic [DATA_W-1:0] wr_data = '0;

    int errors = 0;
    int checks = 0;

    ram_sp_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) bus_big ();
    ram_sp_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4))  bus_small ();

    assign bus_big.rd_en     = rd_en;
    assign bus_big.wr_en     = wr_en;
    assign bus_big.addr      = addr;
    assign bus_big.wr_data   = wr_data;
    assign bus_big.err_inj   = err_inj;
    assign bus_small.rd_en   = rd_en;
    assign bus_small.wr_en   = wr_en;
    assign bus_small.addr    = addr;
    assign bus_small.wr_data = wr_data;
    assign bus_small.err_inj = err_inj;

    ram_sp_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(256),
                  .INIT_VAL(8'h00), .CNT_W(16)) u_big (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_big)
    );

    ram_sp_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(200),
                  .INIT_VAL(8'h00), .CNT_W(4)) u_small (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_small)
    );

    // Outputs gathered per instance so model and monitor can loop over them.
    logic [DATA_W-1:0] o_rd_data  [2];
    logic              o_rd_valid [2];
    logic              o_busy     [2];
    logic              o_drop     [2];
    logic              o_aerr     [2];
    logic              o_perr     [2];
    logic [15:0]       o_cnt      [2];

    assign o_rd_data[0]  = bus_big.rd_data;
    assign o_rd_valid[0] = bus_big.rd_valid;
    assign o_busy[0]     = bus_big.init_busy;
    assign o_drop[0]     = bus_big.req_drop;
    assign o_aerr[0]     = bus_big.addr_err;
    assign o_perr[0]     = bus_big.par_err;
    assign o_cnt[0]      = bus_big.wr_cnt;
    assign o_rd_data[1]  = bus_small.rd_data;
    assign o_rd_valid[1] = bus_small.rd_valid;
    assign o_busy[1]     = bus_small.init_busy;
    assign o_drop[1]     = bus_small.req_drop;
    assign o_aerr[1]     = bus_small.addr_err;
    assign o_perr[1]     = bus_small.par_err;
    assign o_cnt[1]      = {12'd0, bus_small.wr_cnt};

    function automatic int dep_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    // ---------------- reference model ----------------
    logic [DATA_W:0]   exp_q [2][$];   // {par_err, rd_data} per expected response
    int                init_left [2];
    logic [DATA_W-1:0] mmem [2][256];
    logic              mbad [2][256];
    int                mcnt [2];
    logic              e_drop [2];
    logic              e_aerr [2];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!sys_rst_n) begin
                init_left[k] = dep_of(k);
                mcnt[k]      = 0;
                e_drop[k]    = 1'b0;
                e_aerr[k]    = 1'b0;
                exp_q[k].delete();
                for (int i = 0; i < 256; i++) begin
                    mmem[k][i] = 8'h00;
                    mbad[k][i] = 1'b0;
                end
            end else if (init_left[k] > 0) begin
                e_drop[k]    = rd_en | wr_en;
                e_aerr[k]    = 1'b0;
                init_left[k] = init_left[k] - 1;
            end else begin
                e_drop[k] = 1'b0;
                e_aerr[k] = (rd_en | wr_en) && (int'(addr) >= dep_of(k));
                if (rd_en) begin
                    if (int'(addr) < dep_of(k)) begin
                        exp_q[k].push_back({PAR & mbad[k][addr], mmem[k][addr]});
                    end else begin
                        exp_q[k].push_back({1'b0, 8'h00});
                    end
                end
                if (wr_en && (int'(addr) < dep_of(k))) begin
                    mmem[k][addr] = wr_data;
                    mbad[k][addr] = err_inj;
                    if (mcnt[k] < cnt_max(k)) mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h",
                     name, k, $time, act, exp);
        end
    endtask

    logic [DATA_W:0] popped;

    always @(negedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!sys_rst_n) begin
                check("rst_rd_data",   k, 32'(o_rd_data[k]), 32'h0);
                check("rst_rd_valid",  k, 32'(o_rd_valid[k]), 32'h0);
                check("rst_init_busy", k, 32'(o_busy[k]), 32'h1);
                check("rst_req_drop",  k, 32'(o_drop[k]), 32'h0);
                check("rst_addr_err",  k, 32'(o_aerr[k]), 32'h0);
                check("rst_par_err",   k, 32'(o_perr[k]), 32'h0);
                check("rst_wr_cnt",    k, 32'(o_cnt[k]), 32'h0);
            end else begin
                check("init_busy", k, 32'(o_busy[k]), 32'(init_left[k] > 0));
                check("req_drop",  k, 32'(o_drop[k]), 32'(e_drop[k]));
                check("addr_err",  k, 32'(o_aerr[k]), 32'(e_aerr[k]));
                check("wr_cnt",    k, 32'(o_cnt[k]), 32'(mcnt[k]));
                check("rd_valid",  k, 32'(o_rd_valid[k]), 32'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    popped = exp_q[k].pop_front();
                    if (o_rd_valid[k]) begin
                        check("rd_data", k, 32'(o_rd_data[k]), 32'(popped[DATA_W-1:0]));
                        check("par_err", k, 32'(o_perr[k]), 32'(popped[DATA_W]));
                    end
                end else begin
                    check("par_err_idle", k, 32'(o_perr[k]), 32'h0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic e);
        @(negedge sys_clk);
        #1;
        rd_en   = r;
        wr_en   = w;
        addr    = a;
        wr_data = d;
        err_inj = e;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int n);
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; err_inj = 1'b0;
        repeat (n) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_init_done();
        for (int i = 0; i < 400 && (o_busy[0] || o_busy[1]); i++) idle(1);
        check("init_timeout", 0, 32'(o_busy[0] | o_busy[1]), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset(3);

        // Requests on cycles 10 and 20 of the sweep are dropped.
        idle(9);
        drive(1'b1, 1'b1, 8'd10, 8'h55, 1'b0);
        idle(9);
        drive(1'b1, 1'b1, 8'd10, 8'h55, 1'b0);
        wait_init_done();
        idle(2);

        // Every word reads back as INIT_VAL (zero beyond DEPTH on dut1).
        for (int a = 0; a < 256; a++) drive(1'b1, 1'b0, 8'(a), 8'h00, 1'b0);
        idle(2);

        // Fill with address pattern, then read back-to-back.
        for (int a = 0; a < 256; a++) drive(1'b0, 1'b1, 8'(a), 8'(a), 1'b0);
        for (int a = 0; a < 256; a++) drive(1'b1, 1'b0, 8'(a), 8'h00, 1'b0);
        idle(2);

        // Read-first collision, then confirm the write landed.
        drive(1'b1, 1'b1, 8'd7, 8'hA5, 1'b0);
        drive(1'b1, 1'b0, 8'd7, 8'h00, 1'b0);
        idle(1);

        // Parity fault injection and out-of-range accesses.
        drive(1'b0, 1'b1, 8'd33, 8'h3C, 1'b1);
        drive(1'b1, 1'b0, 8'd33, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'd210, 8'h77, 1'b0);
        drive(1'b1, 1'b0, 8'd210, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'd210, 8'h66, 1'b0);
        drive(1'b1, 1'b1, 8'd199, 8'h99, 1'b0);
        drive(1'b1, 1'b0, 8'd199, 8'h00, 1'b0);
        idle(2);

        rand_cycles(600);

        // Reset mid-sweep at cycle 100, with traffic during both sweeps.
        do_reset(2);
        rand_cycles(100);
        do_reset(2);
        rand_cycles(300);
        wait_init_done();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00, 1'b0);
        rand_cycles(200);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_resp.md
Name: ram_sp_resp

Overview:
- Single-port synchronous RAM responder. It sits on the far side of the RAM controller's rd_en/wr_en/addr/wr_data interface and returns read data with a valid strobe.
- After every reset it clears its contents with an init sweep. It also flags illegal accesses and counts accepted writes.
- Its outputs feed the display and data-check logic downstream.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data word width.
- DEPTH, 256, number of words implemented. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- INIT_VAL, 8'd0, value written to every word by the init sweep.
- CNT_W, 16, width of the write counter.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request, sampled every rising edge.
- wr_en  in  1  write request, sampled every rising edge.
- addr  in  ADDR_W  word address for the read or write.
- wr_data  in  DATA_W  write data.
- err_inj  in  1  parity fault-injection control; meaningful only with PARITY_RAM_EN.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe marking rd_data as new.
- init_busy  out  1  high while the init sweep runs.
- req_drop  out  1  one-cycle pulse when a request is ignored during init.
- addr_err  out  1  one-cycle pulse on an access with addr >= DEPTH.
- par_err  out  1  one-cycle parity mismatch pulse, aligned with rd_valid.
- wr_cnt  out  CNT_W  count of accepted writes, saturating.

Behaviour:
- Reset (async, active-low): all outputs take these values.
  - rd_data=0, rd_valid=0, req_drop=0, addr_err=0, par_err=0, wr_cnt=0.
  - init_busy=1, init_ptr=0, FSM=INIT.
  - Memory array contents are not reset directly; the init sweep clears them.
- FSM has two states, INIT and IDLE.
- INIT:
  - Each cycle writes INIT_VAL to mem[init_ptr], then init_ptr increments.
  - When init_ptr==DEPTH-1, that word is written and the FSM moves to IDLE on the same edge.
  - The sweep therefore lasts exactly DEPTH cycles. init_busy falls at the edge that writes the last word.
- Requests during INIT:
  - Any cycle with rd_en|wr_en set is ignored and pulses req_drop for one cycle.
  - No rd_valid, no write, and no wr_cnt change result from it.
- Reset asserted mid-INIT or mid-IDLE aborts all activity. The sweep restarts from address 0 after release.
- IDLE write: wr_en=1 with addr<DEPTH writes mem[addr]<=wr_data at that edge, and wr_cnt increments.
  - wr_cnt saturates at 2**CNT_W-1; it never wraps.
- IDLE read: rd_en=1 with addr<DEPTH loads rd_data<=mem[addr] at that edge and sets rd_valid=1 for exactly the next cycle.
  - Latency is 1 cycle.
  - Back-to-back reads give back-to-back valid cycles.
  - rd_data holds its last value when no read occurs.
- Simultaneous rd_en and wr_en to the same or a different address:
  - Both are performed.
  - The read is read-first: it returns the pre-write content.
- Out of range (addr >= DEPTH, possible only when DEPTH < 2**ADDR_W):
  - A write is discarded and wr_cnt does not change.
  - A read returns rd_data=0 with rd_valid=1.
  - Either case pulses addr_err once per offending cycle, even when rd_en and wr_en are both set.
- Address wrap is not the responder's concern: every addr is decoded independently each cycle.
- All outputs are registered. No combinational path exists from inputs to outputs.

Optional Feature:
- Macro: PARITY_RAM_EN.
- With the macro defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of the data.
  - A write with err_inj=1 stores inverted parity. Init-sweep words always carry correct parity.
  - On each valid in-range read, the stored parity is recomputed and checked.
  - On a mismatch, par_err=1 in the same cycle as rd_valid, while rd_data still returns the stored data.
- Without the macro:
  - Storage is DATA_W bits.
  - err_inj is ignored.
  - par_err is constant 0.

Test Plan:
- Reset release, sampled each cycle:
  - init_busy=1 for exactly 256 cycles, then 0.
  - Then read every address 0..255: each returns 8'h00, and rd_valid pulses 256 times.
- Pulse wr_en and rd_en on cycles 10 and 20 of INIT:
  - req_drop pulses twice.
  - No rd_valid, wr_cnt stays 0, and a later read of addr 10 returns 0.
- Write addr=a, wr_data=a for a=0..255 in consecutive cycles:
  - wr_cnt=256.
  - Reading back addr 0..255 returns 0..255, with rd_valid one cycle after each rd_en.
- With addr 7 holding 8'h07, drive rd_en=wr_en=1, addr=7, wr_data=8'hA5:
  - rd_data=8'h07 on the read.
  - A following read returns 8'hA5.
- Reset pulsed mid-sweep (cycle 100):
  - All outputs return to their reset values.
  - The sweep restarts and init_busy stays high for a full 256 cycles.
- With DEPTH=200:
  - A write to addr 210 pulses addr_err and leaves wr_cnt unchanged.
  - A read of addr 210 gives rd_data=0, rd_valid=1, addr_err=1.
  - With PARITY_RAM_EN, writing 8'h3C with err_inj=1 then reading it back gives rd_data=8'h3C and par_err=1.
